// File: rtl/trigger_counter_bank_if.sv
// Trigger counter bank bus: configuration, event stream and status outputs.
// The master side configures and feeds events; the slave side is the counter bank.
interface trigger_counter_bank_if #(
  parameter int TCN = 4,
  parameter int TCW = 16,
  parameter int TAW = 4
);
  logic                 ctl_rld;
  logic [TCN*TAW-1:0]   cfg_clr_val;
  logic [TCN*TAW-1:0]   cfg_clr_msk;
  logic [TCN*TAW-1:0]   cfg_inc_val;
  logic [TCN*TAW-1:0]   cfg_inc_msk;
  logic [TCN*TAW-1:0]   cfg_dec_val;
  logic [TCN*TAW-1:0]   cfg_dec_msk;
  logic [TCN*TCW-1:0]   cfg_ld;
  logic [TCN*TCW-1:0]   cfg_val;
  logic [TCN*2-1:0]     cfg_cmp;
  logic [TCN-1:0]       cfg_sat;
  logic                 sti_transfer;
  logic [TAW-1:0]       sti_tevent;
  logic [TCN*TCW-1:0]   sts_cnt;
  logic [TCN-1:0]       sts_evt;
  logic [TCN-1:0]       sts_pls;
  logic [TCN-1:0]       sts_ovf;
  logic                 sts_any;

  modport master (
    output ctl_rld, cfg_clr_val, cfg_clr_msk, cfg_inc_val, cfg_inc_msk,
           cfg_dec_val, cfg_dec_msk, cfg_ld, cfg_val, cfg_cmp, cfg_sat,
           sti_transfer, sti_tevent,
    input  sts_cnt, sts_evt, sts_pls, sts_ovf, sts_any
  );

  modport slave (
    input  ctl_rld, cfg_clr_val, cfg_clr_msk, cfg_inc_val, cfg_inc_msk,
           cfg_dec_val, cfg_dec_msk, cfg_ld, cfg_val, cfg_cmp, cfg_sat,
           sti_transfer, sti_tevent,
    output sts_cnt, sts_evt, sts_pls, sts_ovf, sts_any
  );
endinterface

// File: rtl/trigger_counter_bank.sv
// Bank of TCN independent up/down counters driven by one shared trigger event
// stream. Each channel matches the event against its own clear/inc/dec
// value+mask pairs, compares its count against a live threshold and reports a
// match level, a first-match pulse and a sticky overflow/underflow flag.
module trigger_counter_bank #(
  parameter int TCN = 4,
  parameter int TCW = 16,
  parameter int TAW = 4
) (
  input logic                  clk,
  input logic                  rst,
  trigger_counter_bank_if.slave bus
);

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GE = 2'b01;
  localparam logic [1:0] CMP_LE = 2'b10;

  // Masked equality; a zero mask with a zero value matches every event.
  function automatic logic ev_match(input logic [TAW-1:0] ev,
                                    input logic [TAW-1:0] msk,
                                    input logic [TAW-1:0] val);
    return (ev & msk) == val;
  endfunction

  // One inc/dec step with wrap or saturation; MSB of the result is the
  // overflow/underflow indication, the rest is the next count.
  function automatic logic [TCW:0] step_cnt(input logic [TCW-1:0] cnt,
                                            input logic           inc,
                                            input logic           dec,
                                            input logic           sat);
    logic [TCW-1:0] nxt;
    logic           ovf;
    nxt = cnt;
    ovf = 1'b0;
    if (inc && !dec) begin
      if (cnt == {TCW{1'b1}}) begin
        ovf = 1'b1;
        if (!sat) nxt = '0;
      end else begin
        nxt = cnt + TCW'(1);
      end
    end else if (dec && !inc) begin
      if (cnt == '0) begin
        ovf = 1'b1;
        if (!sat) nxt = {TCW{1'b1}};
      end else begin
        nxt = cnt - TCW'(1);
      end
    end
    return {ovf, nxt};
  endfunction

  // Unsigned threshold compare; mode 11 disables the channel's match.
  function automatic logic cmp_hit(input logic [TCW-1:0] cnt,
                                   input logic [TCW-1:0] val,
                                   input logic [1:0]     mode);
    logic hit;
    case (mode)
      CMP_EQ:  hit = (cnt == val);
      CMP_GE:  hit = (cnt >= val);
      CMP_LE:  hit = (cnt <= val);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic [TCN-1:0][TCW-1:0] cnt_p1;
  logic [TCN-1:0][TCW-1:0] cnt_nx;
  logic [TCN-1:0]          ovf_p1;
  logic [TCN-1:0]          ovf_nx;
  logic [TCN-1:0]          evt_p1;
  logic [TCN-1:0]          evt_c;

  for (genvar n = 0; n < TCN; n++) begin : g_ch
    logic           clr_hit;
    logic           inc_hit;
    logic           dec_hit;
    logic [TCW-1:0] ld;
    logic [TCW:0]   stepped;

    assign clr_hit = ev_match(bus.sti_tevent, bus.cfg_clr_msk[n*TAW +: TAW],
                              bus.cfg_clr_val[n*TAW +: TAW]);
    assign inc_hit = ev_match(bus.sti_tevent, bus.cfg_inc_msk[n*TAW +: TAW],
                              bus.cfg_inc_val[n*TAW +: TAW]);
    assign dec_hit = ev_match(bus.sti_tevent, bus.cfg_dec_msk[n*TAW +: TAW],
                              bus.cfg_dec_val[n*TAW +: TAW]);
    assign ld      = bus.cfg_ld[n*TCW +: TCW];
    assign stepped = step_cnt(cnt_p1[n], inc_hit, dec_hit, bus.cfg_sat[n]);

    // Reload beats the event stream; a clear event beats inc/dec.
    assign cnt_nx[n] = bus.ctl_rld       ? ld :
                       !bus.sti_transfer ? cnt_p1[n] :
                       clr_hit           ? ld : stepped[TCW-1:0];
    assign ovf_nx[n] = bus.ctl_rld ? 1'b0 :
                       (bus.sti_transfer && !clr_hit) ? (ovf_p1[n] | stepped[TCW]) :
                       ovf_p1[n];

    assign evt_c[n] = cmp_hit(cnt_p1[n], bus.cfg_val[n*TCW +: TCW],
                              bus.cfg_cmp[n*2 +: 2]);
  end

  // Stage p1: counters, sticky flags and the previous match level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
      ovf_p1 <= '0;
      evt_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_nx;
      ovf_p1 <= ovf_nx;
      evt_p1 <= evt_c;
    end
  end

  assign bus.sts_cnt = cnt_p1;
  assign bus.sts_ovf = ovf_p1;
  assign bus.sts_evt = evt_c;
  assign bus.sts_pls = evt_c & ~evt_p1;
  assign bus.sts_any = |evt_c;

endmodule

// File: tb/tb_trigger_counter_bank.sv
// Directed bench for trigger_counter_bank (TCN=4, TCW=4, TAW=4). Stimulus
// pushes hand-computed expectations tagged with the cycle they belong to; a
// monitor on the falling edge pops and compares them against the DUT.
module tb_trigger_counter_bank;
  localparam int TCN = 4;
  localparam int TCW = 4;
  localparam int TAW = 4;

  typedef struct {
    int cyc;
    int ch;   // -1 selects the sts_any check (value in evt)
    int cnt;
    bit ovf;
    bit evt;
    bit pls;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc_n  = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  exp_t sbq[$];

  trigger_counter_bank_if #(.TCN(TCN), .TCW(TCW), .TAW(TAW)) bus ();

  trigger_counter_bank #(.TCN(TCN), .TCW(TCW), .TAW(TAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic cmp(input string nm, input int cyc, input int ch,
                     input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc %0d ch %0d: got %0d, want %0d", nm, cyc, ch, act, req);
    end
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc_n) begin
      e = sbq.pop_front();
      if (e.ch < 0) begin
        cmp("any", e.cyc, e.ch, int'(bus.sts_any), int'(e.evt));
      end else begin
        cmp("cnt", e.cyc, e.ch, int'(bus.sts_cnt[e.ch*TCW +: TCW]), e.cnt);
        cmp("ovf", e.cyc, e.ch, int'(bus.sts_ovf[e.ch]), int'(e.ovf));
        cmp("evt", e.cyc, e.ch, int'(bus.sts_evt[e.ch]), int'(e.evt));
        cmp("pls", e.cyc, e.ch, int'(bus.sts_pls[e.ch]), int'(e.pls));
      end
    end
  end

  task automatic chk(input int ch, input int cnt, input bit ovf,
                     input bit evt, input bit pls);
    exp_t e;
    e = '{cyc: cyc_n, ch: ch, cnt: cnt, ovf: ovf, evt: evt, pls: pls};
    sbq.push_back(e);
  endtask

  task automatic chk_any(input bit v);
    exp_t e;
    e = '{cyc: cyc_n, ch: -1, cnt: 0, ovf: 1'b0, evt: v, pls: 1'b0};
    sbq.push_back(e);
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic xfer(input logic t, input logic [TAW-1:0] ev);
    bus.sti_transfer = t;
    bus.sti_tevent   = ev;
  endtask

  task automatic set_ch(input int ch,
                        input logic [TAW-1:0] clr_m, input logic [TAW-1:0] clr_v,
                        input logic [TAW-1:0] inc_m, input logic [TAW-1:0] inc_v,
                        input logic [TAW-1:0] dec_m, input logic [TAW-1:0] dec_v,
                        input logic [TCW-1:0] ld, input logic [TCW-1:0] val,
                        input logic [1:0] cmpm, input logic sat);
    bus.cfg_clr_msk[ch*TAW +: TAW] = clr_m;
    bus.cfg_clr_val[ch*TAW +: TAW] = clr_v;
    bus.cfg_inc_msk[ch*TAW +: TAW] = inc_m;
    bus.cfg_inc_val[ch*TAW +: TAW] = inc_v;
    bus.cfg_dec_msk[ch*TAW +: TAW] = dec_m;
    bus.cfg_dec_val[ch*TAW +: TAW] = dec_v;
    bus.cfg_ld[ch*TCW +: TCW]      = ld;
    bus.cfg_val[ch*TCW +: TCW]     = val;
    bus.cfg_cmp[ch*2 +: 2]         = cmpm;
    bus.cfg_sat[ch]                = sat;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Event 1111 is never issued, so 1111/1111 is a matcher that never fires.
    rst = 1'b1;
    bus.ctl_rld = 1'b0;
    xfer(1'b0, 4'b0000);
    set_ch(0, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'd5, 4'd3, 2'b00, 1'b1);
    set_ch(1, 4'b1111, 4'b1111, 4'b0001, 4'b0001, 4'b1111, 4'b1111, 4'd14, 4'd0, 2'b11, 1'b0);
    set_ch(2, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'd7, 4'd0, 2'b11, 1'b1);
    set_ch(3, 4'b1111, 4'b1111, 4'b0001, 4'b0001, 4'b1111, 4'b1111, 4'd0, 4'd2, 2'b10, 1'b0);

    // reset state: ch3 LE 2 matches count 0, evt_q cleared -> pulse
    go();
    chk(0, 0, 0, 0, 0); chk(1, 0, 0, 0, 0); chk(2, 0, 0, 0, 0); chk(3, 0, 0, 1, 1); chk_any(1);
    at_neg(); rst = 1'b0;
    go();
    chk(3, 0, 0, 1, 0);

    // increment ch0/ch1/ch3, ch0 EQ 3, ch3 GE 2
    at_neg(); bus.cfg_cmp[3*2 +: 2] = 2'b01; xfer(1'b1, 4'b0001);
    go();
    chk(0, 1, 0, 0, 0); chk(1, 1, 0, 0, 0); chk(3, 1, 0, 0, 0); chk_any(0);
    go();
    chk(0, 2, 0, 0, 0); chk(3, 2, 0, 1, 1); chk_any(1);
    go();
    chk(0, 3, 0, 1, 1); chk(1, 3, 0, 0, 0); chk(3, 3, 0, 1, 0); chk_any(1);
    at_neg(); xfer(1'b0, 4'b0001);
    go();
    chk(0, 3, 0, 1, 0); chk(3, 3, 0, 1, 0);
    at_neg(); xfer(1'b1, 4'b0001);
    go();
    chk(0, 4, 0, 0, 0); chk(3, 4, 0, 1, 0);

    // live compare-mode changes on ch3 (applied between edges)
    at_neg(); xfer(1'b0, 4'b0001);
    go(); bus.cfg_cmp[3*2 +: 2] = 2'b10;
    chk(3, 4, 0, 0, 0); chk_any(0);
    go(); bus.cfg_val[3*TCW +: TCW] = 4'd5;
    chk(3, 4, 0, 1, 1); chk_any(1);
    go(); bus.cfg_cmp[3*2 +: 2] = 2'b11;
    chk(3, 4, 0, 0, 0); chk_any(0);

    // inc+dec on ch0 holds; ch2 sat underflow at 0
    at_neg(); xfer(1'b1, 4'b0011);
    go();
    chk(0, 4, 0, 0, 0); chk(1, 5, 0, 0, 0); chk(2, 0, 1, 0, 0); chk(3, 5, 0, 0, 0);
    // clr+inc on ch0 loads preset
    at_neg(); xfer(1'b1, 4'b0101); bus.cfg_ld[0*TCW +: TCW] = 4'd9;
    go();
    chk(0, 9, 0, 0, 0); chk(1, 6, 0, 0, 0); chk(2, 0, 1, 0, 0); chk(3, 6, 0, 0, 0);
    // same event without transfer changes nothing
    at_neg(); xfer(1'b0, 4'b0101);
    go();
    chk(0, 9, 0, 0, 0); chk(1, 6, 0, 0, 0); chk(2, 0, 1, 0, 0); chk(3, 6, 0, 0, 0);

    // reload wins over a simultaneous transfer; then ch1 wraps
    at_neg(); bus.ctl_rld = 1'b1; xfer(1'b1, 4'b0001);
    go();
    chk(0, 9, 0, 0, 0); chk(1, 14, 0, 0, 0); chk(2, 7, 0, 0, 0); chk(3, 0, 0, 0, 0);
    at_neg(); bus.ctl_rld = 1'b0;
    go();
    chk(0, 10, 0, 0, 0); chk(1, 15, 0, 0, 0);
    go();
    chk(0, 11, 0, 0, 0); chk(1, 0, 1, 0, 0);
    go();
    chk(1, 1, 1, 0, 0); chk(2, 7, 0, 0, 0);

    // ch1 saturating at the top
    at_neg(); bus.cfg_sat[1] = 1'b1; bus.ctl_rld = 1'b1; xfer(1'b0, 4'b0001);
    go();
    chk(1, 14, 0, 0, 0);
    at_neg(); bus.ctl_rld = 1'b0; xfer(1'b1, 4'b0001);
    go();
    chk(1, 15, 0, 0, 0);
    go();
    chk(1, 15, 1, 0, 0);
    go();
    chk(1, 15, 1, 0, 0); chk(0, 12, 0, 0, 0);

    // ch2 wrapping below zero, then reload clears ovf
    at_neg(); xfer(1'b0, 4'b0001); bus.cfg_ld[2*TCW +: TCW] = 4'd0; bus.cfg_sat[2] = 1'b0;
    bus.ctl_rld = 1'b1;
    go();
    chk(2, 0, 0, 0, 0); chk(1, 14, 0, 0, 0);
    at_neg(); bus.ctl_rld = 1'b0; xfer(1'b1, 4'b0010);
    go();
    chk(2, 15, 1, 0, 0); chk(0, 8, 0, 0, 0); chk(1, 14, 0, 0, 0);
    go();
    chk(2, 14, 1, 0, 0); chk(0, 7, 0, 0, 0);
    at_neg(); xfer(1'b0, 4'b0010); bus.cfg_ld[2*TCW +: TCW] = 4'd3; bus.ctl_rld = 1'b1;
    go();
    chk(2, 3, 0, 0, 0); chk(0, 9, 0, 0, 0);

    // build up ovf on ch1, then rst beats reload and transfer
    at_neg(); bus.ctl_rld = 1'b0; xfer(1'b1, 4'b0001);
    go();
    chk(1, 15, 0, 0, 0);
    go();
    chk(1, 15, 1, 0, 0); chk(0, 11, 0, 0, 0);
    at_neg(); rst = 1'b1; bus.ctl_rld = 1'b1;
    go();
    chk(0, 0, 0, 0, 0); chk(1, 0, 0, 0, 0); chk(2, 0, 0, 0, 0); chk(3, 0, 0, 0, 0); chk_any(0);
    at_neg(); rst = 1'b0; bus.ctl_rld = 1'b0; xfer(1'b0, 4'b0000);
    go();
    chk(0, 0, 0, 0, 0); chk(1, 0, 0, 0, 0);

    at_neg();
    cmp("drain", cyc_n, -1, sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/trigger_counter_bank.md
Name: trigger_counter_bank

Overview:
- Multi-channel successor to the single trigger counter. TCN independent counters share one trigger-event stream.
- Each channel has its own clear/increment/decrement event matchers, a preset value, a compare mode and a wrap/saturate mode.
- Each channel produces a level match, a first-match pulse and a sticky overflow flag.
- Sits between the trigger event encoder and the trigger state machine, which consumes sts_evt/sts_pls.

Parameters:
- TCN, 4, number of counter channels (>=1)
- TCW, 16, counter width per channel (>=2)
- TAW, 4, trigger event vector width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ctl_rld  in  1  synchronous reload: all counters <= cfg_ld, all sts_ovf <= 0
- cfg_clr_val  in  TCN*TAW  per-channel clear event value; channel n at bits [n*TAW +: TAW], same packing for all per-channel buses
- cfg_clr_msk  in  TCN*TAW  clear event mask
- cfg_inc_val  in  TCN*TAW  increment event value
- cfg_inc_msk  in  TCN*TAW  increment event mask
- cfg_dec_val  in  TCN*TAW  decrement event value
- cfg_dec_msk  in  TCN*TAW  decrement event mask
- cfg_ld  in  TCN*TCW  preset value, loaded on clear event or ctl_rld
- cfg_val  in  TCN*TCW  compare value
- cfg_cmp  in  TCN*2  compare mode: 00 EQ, 01 GE, 10 LE, 11 off
- cfg_sat  in  TCN  1 = saturate at bounds, 0 = wrap
- sti_transfer  in  1  event vector valid this cycle
- sti_tevent  in  TAW  trigger event vector
- sts_cnt  out  TCN*TCW  current counter values
- sts_evt  out  TCN  compare match level
- sts_pls  out  TCN  first cycle of sts_evt high
- sts_ovf  out  TCN  sticky overflow/underflow flag
- sts_any  out  1  OR of sts_evt

Behaviour:
- Matchers per channel: clr/inc/dec = ((sti_tevent & msk) == val). A zero mask with zero value always matches.
- Priority per clk edge: rst > ctl_rld > (sti_transfer: clr > inc/dec) > hold.
- rst: cnt = 0, ovf = 0, evt_q = 0 for every channel.
- ctl_rld: cnt = cfg_ld, ovf = 0. Applies whatever sti_transfer is.
- sti_transfer=0: cnt and ovf hold.
- sti_transfer=1, per-channel update:
  - clr: cnt = cfg_ld; ovf unchanged.
  - inc and dec both: cnt holds.
  - inc only, cnt < 2^TCW-1: cnt + 1.
  - inc only, cnt = 2^TCW-1: ovf = 1; cnt holds if cfg_sat=1, else wraps to 0.
  - dec only, cnt > 0: cnt - 1.
  - dec only, cnt = 0: ovf = 1; cnt holds if cfg_sat=1, else wraps to 2^TCW-1.
- Compare, combinational from the registered cnt and live cfg:
  - EQ: cnt == cfg_val.
  - GE: cnt >= cfg_val.
  - LE: cnt <= cfg_val.
  - off: 0.
  - All comparisons unsigned.
- evt_q registers sts_evt every cycle. sts_pls = sts_evt & ~evt_q.
  - Pulse is one cycle wide, in the first cycle the match holds.
  - After reset evt_q = 0, so a match present immediately after reset produces a pulse.
- sts_cnt mirrors the registers directly; counter latency is one cycle from transfer to sts_cnt/sts_evt.
- sts_any = |sts_evt, combinational.
- Reset values: sts_cnt = 0, sts_ovf = 0. sts_evt/sts_pls/sts_any follow the cfg compare against 0.
- Config changes mid-run take effect immediately on compare; counters are not disturbed.
- Channels are fully independent; one event can clear one channel while incrementing another.

Test Plan:
- TCW=4, ch0 inc_msk=0001 inc_val=0001, cfg_val=3 EQ, 3 transfers with tevent=0001 -> sts_cnt ch0 = 1,2,3. sts_evt ch0 rises on the 3rd update; sts_pls high exactly 1 cycle; sts_any=1.
- ch1 cfg_sat=0, cfg_ld=14, ctl_rld, then 3 inc transfers -> ch1 = 15, 0, 1; sts_ovf ch1 = 1 from the wrap cycle. Repeat with cfg_sat=1 -> ch1 = 15, 15, 15; ovf = 1.
- ch2 at 0: dec transfer with cfg_sat=1 -> stays 0, ovf=1. With cfg_sat=0 -> 15, ovf=1. Then ctl_rld -> ovf=0, cnt=cfg_ld.
- Event matching both inc and dec on ch0 -> cnt unchanged. Event matching clr+inc -> cnt = cfg_ld. Same event with sti_transfer=0 -> no change on any channel.
- ch3 GE cfg_val=2 counting 0..4 -> sts_evt 0,0,1,1,1 with a single pls. Switch cfg_cmp to LE -> evt follows cnt<=2 the same cycle. Switch to off -> evt=0.
- rst asserted mid-count with sti_transfer=1 and ctl_rld=1 -> next cycle all cnt=0, ovf=0; rst wins.
